// File: rtl/edram_ss_pkg.sv
// Shared constants for the FPGA eDRAM subsystem model: geometry defaults,
// APB register map, ID value and CTRL/PEND bit positions.
package edram_ss_pkg;

    localparam int unsigned EDRAM_WIDTH_DEF = 64;
    localparam int unsigned EDRAM_DEPTH_DEF = 4096;

    localparam logic [31:0] REG_ID    = 32'h0000_0000;
    localparam logic [31:0] REG_CTRL  = 32'h0000_0004;
    localparam logic [31:0] REG_PEND  = 32'h0000_0008;
    localparam logic [31:0] REG_RDCNT = 32'h0000_000C;
    localparam logic [31:0] REG_WRCNT = 32'h0000_0010;

    localparam logic [31:0] ID_VALUE = 32'hED5A_0002;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MASK_LO = 1;
    localparam int unsigned PEND_RD      = 0;
    localparam int unsigned PEND_WR      = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_ID,
        SEL_CTRL,
        SEL_PEND,
        SEL_RDCNT,
        SEL_WRCNT
    } reg_sel_e;

    function automatic reg_sel_e reg_decode(input logic [31:0] addr);
        case (addr)
            REG_ID:    return SEL_ID;
            REG_CTRL:  return SEL_CTRL;
            REG_PEND:  return SEL_PEND;
            REG_RDCNT: return SEL_RDCNT;
            REG_WRCNT: return SEL_WRCNT;
            default:   return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/edram_ss_bram.sv
// Simple dual-port RAM (one read port, one write port) with byte enables.
// Read-first: a same-address read and write in one cycle returns the old word.
module edram_ss_bram #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [WIDTH/8-1:0]       i_wbe
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < WIDTH/8; b++) begin
                if (i_wbe[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/edram_ss_fpga_model.sv
// FPGA stand-in for the eDRAM subsystem: BRAM-backed array behind the mem
// valid/ready interface, fixed read latency, APB control/status window.
module edram_ss_fpga_model
    import edram_ss_pkg::*;
#(
    parameter  int unsigned EDRAM_WIDTH    = EDRAM_WIDTH_DEF,
    parameter  int unsigned EDRAM_DEPTH    = EDRAM_DEPTH_DEF,
    parameter  int unsigned ARR_INST_WIDTH = 2,
    parameter  int unsigned ARR_INST_DEPTH = 1,
    parameter  int unsigned RD_LAT         = 2,
    parameter  int unsigned APB_ADDR_W     = 12,
    parameter  int unsigned APB_DATA_W     = 32,
    localparam int unsigned ARR_WIDTH      = EDRAM_WIDTH * ARR_INST_WIDTH,
    localparam int unsigned ARR_DEPTH      = EDRAM_DEPTH * ARR_INST_DEPTH,
    localparam int unsigned ARR_DEPTH_W    = $clog2(ARR_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rvalid,
    input  logic [ARR_DEPTH_W-1:0]  raddr,
    output logic                    rready,
    output logic [ARR_WIDTH-1:0]    rdata,
    output logic                    rdata_vld,
    input  logic                    wvalid,
    input  logic [ARR_DEPTH_W-1:0]  waddr,
    input  logic [ARR_WIDTH-1:0]    wdata,
    input  logic [ARR_WIDTH/8-1:0]  wbe,
    output logic                    wready,
    input  logic [APB_ADDR_W-1:0]   apb_PADDR,
    input  logic                    apb_PENABLE,
    input  logic                    apb_PSEL,
    input  logic [APB_DATA_W/8-1:0] apb_PSTRB,
    input  logic [APB_DATA_W-1:0]   apb_PWDATA,
    input  logic                    apb_PWRITE,
    output logic [APB_DATA_W-1:0]   apb_PRDATA,
    output logic                    apb_PREADY,
    output logic                    apb_PSLVERR,
    output logic [1:0]              irq,
    output logic [1:0]              irq_clear_p
);

    logic [2:0]            r_ctrl;
    logic [1:0]            r_pend;
    logic [1:0]            r_clrp;
    logic [APB_DATA_W-1:0] r_rdcnt;
    logic [APB_DATA_W-1:0] r_wrcnt;
    logic [RD_LAT-1:0]     r_vpipe;
    logic [ARR_WIDTH-1:0]  r_rdata_hold;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [ARR_WIDTH-1:0]  w_bram_q;
    logic [ARR_WIDTH-1:0]  w_rd_q;
    reg_sel_e              w_sel;
    logic                  w_apb_acc;
    logic                  w_apb_wr;
    logic [1:0]            w_set;
    logic [1:0]            w_w1c;

    assign rready   = r_ctrl[CTRL_EN];
    assign wready   = r_ctrl[CTRL_EN];
    assign w_rd_acc = rvalid & rready;
    assign w_wr_acc = wvalid & wready;

    edram_ss_bram #(
        .WIDTH (ARR_WIDTH),
        .DEPTH (ARR_DEPTH)
    ) u_bram (
        .clk     (clk),
        .i_re    (w_rd_acc),
        .i_raddr (raddr),
        .o_rdata (w_bram_q),
        .i_we    (w_wr_acc),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_wbe   (wbe)
    );

    // The BRAM output register is the first latency stage; extra stages carry data only.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign w_rd_q = w_bram_q;
        end else begin : g_latn
            logic [ARR_WIDTH-1:0] r_dreg [RD_LAT-1];
            always_ff @(posedge clk) begin
                r_dreg[0] <= w_bram_q;
                for (int unsigned i = 1; i < RD_LAT - 1; i++) r_dreg[i] <= r_dreg[i-1];
            end
            assign w_rd_q = r_dreg[RD_LAT-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_rd_acc;
            for (int unsigned i = 1; i < RD_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
        end
    end

    assign rdata_vld = r_vpipe[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_rdata_hold <= '0;
        else if (rdata_vld) r_rdata_hold <= w_rd_q;
    end

    assign rdata = rdata_vld ? w_rd_q : r_rdata_hold;

    assign w_sel       = reg_decode(32'(apb_PADDR));
    assign w_apb_acc   = apb_PSEL & apb_PENABLE;
    assign w_apb_wr    = w_apb_acc & apb_PWRITE;
    assign apb_PREADY  = 1'b1;
    assign apb_PSLVERR = w_apb_acc & (w_sel == SEL_NONE);

    always_comb begin
        apb_PRDATA = '0;
        if (apb_PSEL && !apb_PWRITE) begin
            case (w_sel)
                SEL_ID:    apb_PRDATA = APB_DATA_W'(ID_VALUE);
                SEL_CTRL:  apb_PRDATA = APB_DATA_W'(r_ctrl);
                SEL_PEND:  apb_PRDATA = APB_DATA_W'(r_pend);
                SEL_RDCNT: apb_PRDATA = r_rdcnt;
                SEL_WRCNT: apb_PRDATA = r_wrcnt;
                default:   apb_PRDATA = '0;
            endcase
        end
    end

    // A same-cycle set beats a W1C, and suppresses the clear pulse.
    assign w_set[PEND_RD] = rdata_vld;
    assign w_set[PEND_WR] = w_wr_acc;
    assign w_w1c = (w_apb_wr && w_sel == SEL_PEND) ? apb_PWDATA[1:0] : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl  <= '0;
            r_pend  <= '0;
            r_clrp  <= '0;
            r_rdcnt <= '0;
            r_wrcnt <= '0;
        end else begin
            if (w_apb_wr && w_sel == SEL_CTRL && apb_PSTRB[0]) r_ctrl <= apb_PWDATA[2:0];
            r_pend <= w_set | (r_pend & ~w_w1c);
            r_clrp <= w_w1c & r_pend & ~w_set;
            if (w_apb_wr && w_sel == SEL_RDCNT) r_rdcnt <= apb_PWDATA;
            else if (w_rd_acc)                  r_rdcnt <= r_rdcnt + APB_DATA_W'(1);
            if (w_apb_wr && w_sel == SEL_WRCNT) r_wrcnt <= apb_PWDATA;
            else if (w_wr_acc)                  r_wrcnt <= r_wrcnt + APB_DATA_W'(1);
        end
    end

    assign irq         = r_pend & r_ctrl[CTRL_MASK_LO +: 2];
    assign irq_clear_p = r_clrp;

endmodule

// File: tb/tb_edram_ss_fpga_model.sv
// Scoreboard bench for edram_ss_fpga_model: reads push expected data and
// arrival cycle; a negedge monitor pops and compares on each rdata_vld.
module tb_edram_ss_fpga_model;

    localparam int RD_LAT = 2;
    localparam int W      = 128;
    localparam int AW     = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          rvalid;
    logic [AW-1:0] raddr;
    logic          rready;
    logic [W-1:0]  rdata;
    logic          rdata_vld;
    logic          wvalid;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [W/8-1:0] wbe;
    logic          wready;
    logic [11:0]   apb_PADDR;
    logic          apb_PENABLE;
    logic          apb_PSEL;
    logic [3:0]    apb_PSTRB;
    logic [31:0]   apb_PWDATA;
    logic          apb_PWRITE;
    logic [31:0]   apb_PRDATA;
    logic          apb_PREADY;
    logic          apb_PSLVERR;
    logic [1:0]    irq;
    logic [1:0]    irq_clear_p;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] model [4096];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           vld_seen = 0;
    int           wr_cnt_model = 0;

    edram_ss_fpga_model #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .rvalid(rvalid), .raddr(raddr), .rready(rready),
        .rdata(rdata), .rdata_vld(rdata_vld),
        .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .wbe(wbe), .wready(wready),
        .apb_PADDR(apb_PADDR), .apb_PENABLE(apb_PENABLE), .apb_PSEL(apb_PSEL),
        .apb_PSTRB(apb_PSTRB), .apb_PWDATA(apb_PWDATA), .apb_PWRITE(apb_PWRITE),
        .apb_PRDATA(apb_PRDATA), .apb_PREADY(apb_PREADY), .apb_PSLVERR(apb_PSLVERR),
        .irq(irq), .irq_clear_p(irq_clear_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: data and arrival cycle of every rdata_vld pulse.
    always @(negedge clk) begin
        if (rdata_vld) begin
            exp_t e;
            vld_seen++;
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL rd_unexpected got rdata=%h at cyc %0d, expected no pulse", rdata, cyc);
            end else begin
                e = sb_q.pop_front();
                if (rdata !== e.data || cyc !== e.cyc)
                    $display("FAIL rd_scoreboard got data=%h cyc=%0d, expected data=%h cyc=%0d",
                             rdata, cyc, e.data, e.cyc);
                else
                    n_pass++;
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W/8-1:0] be);
        @(negedge clk);
        wvalid = 1'b1; waddr = a; wdata = d; wbe = be;
        n_checks++;
        if (wready !== 1'b1) $display("FAIL wready got %b expected 1", wready); else n_pass++;
        for (int b = 0; b < W/8; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        wr_cnt_model++;
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic issue_read(input logic [AW-1:0] a);
        @(negedge clk);
        rvalid = 1'b1; raddr = a;
        sb_q.push_back('{model[a], cyc + RD_LAT});
    endtask

    task automatic end_reads();
        @(negedge clk);
        rvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL %s_drain got %0d outstanding, expected 0", name, sb_q.size());
        else n_pass++;
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        apb_PSEL = 1'b1; apb_PENABLE = 1'b0; apb_PWRITE = 1'b1;
        apb_PADDR = a; apb_PWDATA = d; apb_PSTRB = s;
        @(negedge clk);
        apb_PENABLE = 1'b1;
        @(negedge clk);
        apb_PSEL = 1'b0; apb_PENABLE = 1'b0; apb_PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic err);
        @(negedge clk);
        apb_PSEL = 1'b1; apb_PENABLE = 1'b0; apb_PWRITE = 1'b0; apb_PADDR = a;
        @(negedge clk);
        apb_PENABLE = 1'b1;
        #1;
        d = apb_PRDATA; err = apb_PSLVERR;
        @(negedge clk);
        apb_PSEL = 1'b0; apb_PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rvalid = 1'b0; raddr = '0; wvalid = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        apb_PADDR = '0; apb_PENABLE = 1'b0; apb_PSEL = 1'b0; apb_PSTRB = '0;
        apb_PWDATA = '0; apb_PWRITE = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rdata_vld !== 1'b0) $display("FAIL rst_vld got %b expected 0", rdata_vld); else n_pass++;
        n_checks++; if (rdata !== '0) $display("FAIL rst_rdata got %h expected 0", rdata); else n_pass++;
        n_checks++; if (rready !== 1'b0) $display("FAIL rst_rready got %b expected 0", rready); else n_pass++;
        n_checks++; if (irq !== 2'b00) $display("FAIL rst_irq got %b expected 00", irq); else n_pass++;
        n_checks++; if (irq_clear_p !== 2'b00) $display("FAIL rst_clrp got %b expected 00", irq_clear_p); else n_pass++;
        n_checks++; if (apb_PREADY !== 1'b1) $display("FAIL rst_pready got %b expected 1", apb_PREADY); else n_pass++;
        n_checks++; if (apb_PSLVERR !== 1'b0) $display("FAIL rst_pslverr got %b expected 0", apb_PSLVERR); else n_pass++;
        n_checks++; if (apb_PRDATA !== 32'h0) $display("FAIL rst_prdata got %h expected 0", apb_PRDATA); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_rw();
        logic [W-1:0] ones;
        ones = '1;
        apb_wr(12'h004, 32'h1, 4'h1);
        n_checks++; if (rready !== 1'b1) $display("FAIL en_rready got %b expected 1", rready); else n_pass++;
        do_write(12'd5, ones, '1);
        issue_read(12'd5);
        end_reads();
        drain("basic");
        @(negedge clk);
        n_checks++; if (rdata !== ones) $display("FAIL rdata_hold got %h expected %h", rdata, ones); else n_pass++;
    endtask

    task automatic test_byte_enable();
        do_write(12'd7, '0, '1);
        do_write(12'd7, '1, 16'h0001);
        issue_read(12'd7);
        end_reads();
        drain("wbe");
    endtask

    task automatic test_read_first();
        do_write(12'd9, 128'h1234, '1);
        @(negedge clk);
        rvalid = 1'b1; raddr = 12'd9;
        wvalid = 1'b1; waddr = 12'd9; wdata = 128'hBEEF_0000_CAFE; wbe = '1;
        sb_q.push_back('{model[9], cyc + RD_LAT});
        model[9] = 128'hBEEF_0000_CAFE;
        wr_cnt_model++;
        @(negedge clk);
        rvalid = 1'b0; wvalid = 1'b0;
        issue_read(12'd9);
        end_reads();
        drain("rfirst");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        err;
        for (int i = 0; i < 16; i++) do_write(AW'(i), {4{32'hC0DE_0000 + 32'(i)}}, '1);
        apb_wr(12'h00C, 32'h0, 4'hF);
        for (int i = 0; i < 16; i++) issue_read(AW'(i));
        end_reads();
        drain("b2b");
        apb_rd(12'h00C, d, err);
        n_checks++; if (d !== 32'd16) $display("FAIL rdcnt16 got %0d expected 16", d); else n_pass++;
        apb_rd(12'h010, d, err);
        n_checks++; if (d !== 32'(wr_cnt_model)) $display("FAIL wrcnt got %0d expected %0d", d, wr_cnt_model); else n_pass++;
        apb_rd(12'h008, d, err);
        n_checks++; if (d[0] !== 1'b1) $display("FAIL pend_rd got %b expected 1", d[0]); else n_pass++;
        n_checks++; if (irq[0] !== 1'b0) $display("FAIL irq_masked got %b expected 0", irq[0]); else n_pass++;
        apb_wr(12'h004, 32'h3, 4'h1);
        n_checks++; if (irq[0] !== 1'b1) $display("FAIL irq_unmasked got %b expected 1", irq[0]); else n_pass++;
        apb_wr(12'h008, 32'h1, 4'hF);
        n_checks++; if (irq_clear_p !== 2'b01) $display("FAIL clr_pulse got %b expected 01", irq_clear_p); else n_pass++;
        n_checks++; if (irq[0] !== 1'b0) $display("FAIL irq_cleared got %b expected 0", irq[0]); else n_pass++;
        @(negedge clk);
        n_checks++; if (irq_clear_p !== 2'b00) $display("FAIL clr_pulse_end got %b expected 00", irq_clear_p); else n_pass++;
    endtask

    task automatic test_apb();
        logic [31:0] d;
        logic        err;
        apb_rd(12'h000, d, err);
        n_checks++; if (d !== 32'hED5A_0002) $display("FAIL id got %h expected ED5A0002", d); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL id_err got %b expected 0", err); else n_pass++;
        apb_rd(12'h020, d, err);
        n_checks++; if (err !== 1'b1) $display("FAIL bad_addr_err got %b expected 1", err); else n_pass++;
        n_checks++; if (d !== 32'h0) $display("FAIL bad_addr_data got %h expected 0", d); else n_pass++;
        apb_wr(12'h004, 32'h0, 4'h0);
        apb_rd(12'h004, d, err);
        n_checks++; if (d !== 32'h3) $display("FAIL ctrl_strb got %h expected 3", d); else n_pass++;
        apb_wr(12'h00C, 32'hFFFF_FFFF, 4'hF);
        issue_read(12'd3);
        end_reads();
        drain("wrap");
        apb_rd(12'h00C, d, err);
        n_checks++; if (d !== 32'h0) $display("FAIL rdcnt_wrap got %h expected 0", d); else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [31:0] d;
        logic        err;
        int          seen0;
        // Two reads go out without scoreboard entries: neither may surface after reset.
        @(negedge clk);
        rvalid = 1'b1; raddr = 12'd1;
        @(negedge clk);
        raddr = 12'd2;
        @(posedge clk);
        #1;
        rst = 1'b1; rvalid = 1'b0;
        seen0 = vld_seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (vld_seen !== seen0) $display("FAIL rst_no_vld got %0d pulses expected 0", vld_seen - seen0); else n_pass++;
        n_checks++; if (rready !== 1'b0) $display("FAIL rst_mid_rready got %b expected 0", rready); else n_pass++;
        n_checks++; if (rdata !== '0) $display("FAIL rst_mid_rdata got %h expected 0", rdata); else n_pass++;
        apb_rd(12'h004, d, err);
        n_checks++; if (d !== 32'h0) $display("FAIL rst_mid_ctrl got %h expected 0", d); else n_pass++;
        apb_rd(12'h00C, d, err);
        n_checks++; if (d !== 32'h0) $display("FAIL rst_mid_rdcnt got %h expected 0", d); else n_pass++;
        apb_rd(12'h010, d, err);
        n_checks++; if (d !== 32'h0) $display("FAIL rst_mid_wrcnt got %h expected 0", d); else n_pass++;
        apb_rd(12'h008, d, err);
        n_checks++; if (d !== 32'h0) $display("FAIL rst_mid_pend got %h expected 0", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_byte_enable();
        test_read_first();
        test_back_to_back();
        test_apb();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
